// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-block instruction cache
// Hits are combinational in IDLE; a miss parks in FILL until memory drops iwait.
module icache #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [31:0] miss_cnt
);

  localparam int IB = $clog2(NSETS);
  localparam int TW = 30 - IB;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, next_state;
  logic [NSETS-1:0]  valid;
  logic [TW-1:0]     tags [NSETS];
  logic [31:0]       data [NSETS];
  logic [31:0]       miss_addr;
  logic              fill_done;

  logic [IB-1:0]     req_idx, miss_idx;
  logic [TW-1:0]     req_tag, miss_tag;
  logic [1:0]        unused_byte_bits;

  assign req_idx          = imemaddr[IB+1:2];
  assign req_tag          = imemaddr[31:IB+2];
  assign miss_idx         = miss_addr[IB+1:2];
  assign miss_tag         = miss_addr[31:IB+2];
  assign unused_byte_bits = imemaddr[1:0];

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = {imemaddr[31:2], 2'b00};
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN && !flush) begin
          if (valid[req_idx] && tags[req_idx] == req_tag) begin
            ihit     = 1'b1;
            imemload = data[req_idx];
          end else begin
            next_state = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        // flush wins over a completing fill: the returned word is dropped
        if (flush) begin
          next_state = IDLE;
        end else if (!iwait) begin
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= 32'h0;
      miss_cnt  <= 32'h0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == FILL)
        miss_addr <= {imemaddr[31:2], 2'b00};
      if (flush)
        valid <= '0;
      else if (fill_done)
        valid[miss_idx] <= 1'b1;
      if (fill_done)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  // Tag/data carry no reset; valid alone qualifies their contents.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache
// Stimulus queues expected hit words; a negedge monitor pops them on every ihit.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic [31:0] miss_cnt;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] sb[$];

  icache #(.NSETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .flush    (flush),
    .miss_cnt (miss_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && ihit) begin
      if (sb.size() == 0) begin
        check("unexpected_hit", imemaddr, 32'hFFFF_FFFF);
      end else begin
        check("hit_data", imemload, sb.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a, input int w, input logic [31:0] d, input string nm);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'h0;
    @(negedge CLK);
    check({nm, "_idle_hit"}, {31'h0, ihit}, 32'h0);
    check({nm, "_idle_iren"}, {31'h0, iREN}, 32'h0);
    check({nm, "_idle_iaddr"}, iaddr, {a[31:2], 2'b00});
    check({nm, "_idle_load"}, imemload, 32'h0);
    cycle();
    for (int i = 0; i < w; i++) begin
      @(negedge CLK);
      check({nm, "_wait_iren"}, {31'h0, iREN}, 32'h1);
      check({nm, "_wait_iaddr"}, iaddr, {a[31:2], 2'b00});
      cycle();
    end
    iwait = 1'b0;
    iload = d;
    @(negedge CLK);
    check({nm, "_fill_iren"}, {31'h0, iREN}, 32'h1);
    check({nm, "_fill_iaddr"}, iaddr, {a[31:2], 2'b00});
    exp_cnt = exp_cnt + 32'd1;
    sb.push_back(d);
    cycle();
    iwait = 1'b1;
    iload = 32'h0;
    @(negedge CLK);
    check({nm, "_post_hit"}, {31'h0, ihit}, 32'h1);
    check({nm, "_cnt"}, miss_cnt, exp_cnt);
    cycle();
    imemREN = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d, input string nm);
    imemREN  = 1'b1;
    imemaddr = a;
    sb.push_back(d);
    @(negedge CLK);
    check({nm, "_hit"}, {31'h0, ihit}, 32'h1);
    check({nm, "_iren"}, {31'h0, iREN}, 32'h0);
    check({nm, "_cnt"}, miss_cnt, exp_cnt);
    cycle();
    imemREN = 1'b0;
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    flush    = 1'b0;
    @(negedge CLK);
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_iren", {31'h0, iREN}, 32'h0);
    check("rst_load", imemload, 32'h0);
    check("rst_cnt", miss_cnt, 32'h0);
    cycle();
    nRST = 1'b1;
    cycle();

    // cold miss, hit, then conflicts on index 0
    do_miss(32'h40, 3, 32'h0050_0093, "cold");
    do_hit(32'h40, 32'h0050_0093, "rehit");
    do_miss(32'h80, 0, 32'h1111_1111, "conf80");
    do_miss(32'h40, 1, 32'h0050_0093, "conf40");
    check("conf_cnt3", miss_cnt, 32'd3);
    do_miss(32'h44, 2, 32'h2222_2222, "idx1");
    do_hit(32'h46, 32'h2222_2222, "idx1_bytes");
    do_hit(32'h40, 32'h0050_0093, "idx0_kept");

    // flush pulse clears everything
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    do_miss(32'h40, 0, 32'h0050_0093, "postflush40");
    do_miss(32'h44, 0, 32'h3333_3333, "postflush44");

    // flush on the same edge a fill would complete
    imemREN  = 1'b1;
    imemaddr = 32'hC0;
    iwait    = 1'b1;
    @(negedge CLK);
    check("fl_idle_iren", {31'h0, iREN}, 32'h0);
    cycle();
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(negedge CLK);
    check("fl_fill_iren", {31'h0, iREN}, 32'h1);
    cycle();
    flush   = 1'b0;
    iwait   = 1'b1;
    imemREN = 1'b0;
    @(negedge CLK);
    check("fl_state_idle", {31'h0, iREN}, 32'h0);
    check("fl_cnt", miss_cnt, exp_cnt);
    cycle();
    do_miss(32'hC0, 1, 32'hCCCC_0000, "fl_nowrite");
    do_miss(32'h40, 0, 32'h0050_0093, "fl_cleared");

    // address moves during FILL; the latched one completes
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    @(negedge CLK);
    cycle();
    imemaddr = 32'h44;
    iwait    = 1'b0;
    iload    = 32'hABCD_0100;
    @(negedge CLK);
    check("chg_iaddr", iaddr, 32'h100);
    check("chg_iren", {31'h0, iREN}, 32'h1);
    exp_cnt = exp_cnt + 32'd1;
    cycle();
    iwait   = 1'b1;
    imemREN = 1'b0;
    @(negedge CLK);
    check("chg_cnt", miss_cnt, exp_cnt);
    cycle();
    do_hit(32'h100, 32'hABCD_0100, "chg_hit");
    do_miss(32'h44, 0, 32'h4444_4444, "chg_new");

    // reset in the middle of a fill
    imemREN  = 1'b1;
    imemaddr = 32'h48;
    @(negedge CLK);
    cycle();
    @(negedge CLK);
    check("rf_fill_iren", {31'h0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    check("rf_iren_async", {31'h0, iREN}, 32'h0);
    check("rf_cnt", miss_cnt, 32'h0);
    cycle();
    nRST    = 1'b1;
    imemREN = 1'b0;
    exp_cnt = 32'h0;
    cycle();
    do_miss(32'h48, 1, 32'h4848_4848, "rf_remiss");

    // counter wrap
    force dut.miss_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    do_miss(32'h4C, 0, 32'h4C4C_4C4C, "wrap");
    check("wrap_zero", miss_cnt, 32'h0);

    check("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NSETS, 16, number of direct-mapped frames; power of two, 2..64.
REQ-002 Port: CLK  input  1  clock; all state updates on rising edge.
REQ-003 Port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 Port: imemREN  input  1  fetch request from datapath.
REQ-005 Port: imemaddr  input  32  fetch byte address from datapath; bits [1:0] ignored.
REQ-006 Port: ihit  output  1  requested word valid on imemload this cycle.
REQ-007 Port: imemload  output  32  instruction word to datapath.
REQ-008 Port: iREN  output  1  read request to memory controller.
REQ-009 Port: iaddr  output  32  word-aligned memory read address.
REQ-010 Port: iwait  input  1  memory busy; fill data is valid on the cycle it is 0 with iREN=1.
REQ-011 Port: iload  input  32  fill data from memory.
REQ-012 Port: flush  input  1  invalidate all frames.
REQ-013 Port: miss_cnt  output  32  count of completed fills.

Function
REQ-014 Address split: IB=log2(NSETS); index = imemaddr[IB+1:2]; tag = imemaddr[31:IB+2] (26 bits at NSETS=16).
REQ-015 Storage per frame: valid bit, tag, 32-bit data word; one word per block.
REQ-016 FSM states: IDLE, FILL.
REQ-017 Hit (combinational): ihit = imemREN & state==IDLE & valid[index] & tag[index]==tag & ~flush.
REQ-018 imemload = data[index] when ihit; 32'h0 otherwise.
REQ-019 IDLE -> FILL when imemREN & ~ihit & ~flush; miss address {imemaddr[31:2],2'b00} latched on that edge.
REQ-020 IDLE with imemREN=0: no state change, iREN=0, ihit=0.
REQ-021 FILL: iREN=1, iaddr = latched miss address; ihit=0.
REQ-022 FILL with iwait=1: hold state, no array write.
REQ-023 FILL with iwait=0: write iload, latched tag, valid=1 into latched index; miss_cnt increments; -> IDLE.
REQ-024 Miss latency: earliest ihit for a missed address is the cycle after the fill edge (1 + memory wait cycles + 1).
REQ-025 imemaddr changing during FILL: fill completes for the latched address; the new address is evaluated in IDLE.
REQ-026 In IDLE, iREN=0 and iaddr = {imemaddr[31:2],2'b00}.
REQ-027 flush (synchronous, any state): all valid bits cleared, state -> IDLE, in-flight fill discarded (no write, no count); flush has priority over a same-cycle fill completion.
REQ-028 miss_cnt wraps 32'hFFFFFFFF -> 0.
REQ-029 Aliasing: a fill overwrites any existing tag/data in its frame.

Reset
REQ-030 nRST=0 asynchronously: all valid bits 0, state IDLE, latched address 0, miss_cnt 0; ihit=0, iREN=0, imemload=0.
REQ-031 Reset asserted during FILL aborts the fill; no frame is written.
REQ-032 Tag/data arrays need no reset value.

Verification
REQ-033 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x00500093 -> iREN=1, iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0x00500093, miss_cnt=1.
REQ-034 Hit after fill: re-request 0x40 -> ihit=1 the same cycle, iREN=0, miss_cnt unchanged.
REQ-035 Conflict: fill 0x40, then 0x80 (same index 0, different tag) -> miss and fill; re-request 0x40 -> miss again; miss_cnt=3.
REQ-036 Flush: after REQ-034, pulse flush one cycle -> 0x40 misses next cycle; flush during FILL with iwait=0 in the same cycle -> no write, miss_cnt unchanged, state IDLE.
REQ-037 Reset mid-fill: assert nRST=0 while in FILL -> iREN=0 immediately; after release, same address misses and miss_cnt=0.
REQ-038 Counter wrap: force miss_cnt=0xFFFFFFFF, complete one fill -> miss_cnt=0.
